// File: rtl/i2s_tx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_tx_sequencer
//  Description : I2S transmit frame sequencer. Drives bit clock, word select
//                and serial data from a half-bit-period enable. Accepts stereo
//                pairs over valid/ready into a one-pair holding buffer, flags
//                underrun, and starts/stops only on frame boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx_sequencer #(
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    bclk_en,
    input  logic                    enable,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [SAMPLE_WIDTH-1:0] s_left,
    input  logic [SAMPLE_WIDTH-1:0] s_right,
    output logic                    i2s_bclk,
    output logic                    i2s_lrclk,
    output logic                    i2s_sdata,
    output logic                    busy,
    output logic                    underrun
);

    localparam int FW = 2 * SAMPLE_WIDTH;
    localparam int BW = $clog2(FW);

    localparam logic [BW-1:0] c_LAST  = BW'(FW - 1);
    localparam logic [BW-1:0] c_LR_LO = BW'(SAMPLE_WIDTH - 1);
    localparam logic [BW-1:0] c_LR_HI = BW'(FW - 2);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_RUN  = 1'b1;

    logic [0:0]              r_state;
    logic [BW-1:0]           r_bidx;
    logic [FW-1:0]           r_shift;
    logic [SAMPLE_WIDTH-1:0] r_hold_l;
    logic [SAMPLE_WIDTH-1:0] r_hold_r;
    logic                    r_full;
    logic                    r_bclk;
    logic                    r_lrclk;
    logic                    r_sdata;
    logic                    r_busy;
    logic                    r_underrun;

    logic                    w_xfer;
    logic                    w_rise;
    logic                    w_fall;
    logic                    w_at_last;
    logic                    w_start;
    logic                    w_stop;
    logic                    w_adv;
    logic                    w_load;
    logic [BW-1:0]           w_bidx_nxt;
    logic                    w_lr_nxt;

    assign w_xfer     = s_valid & ~r_full;
    assign w_rise     = (r_state == c_S_RUN) & bclk_en & ~r_bclk;
    assign w_fall     = (r_state == c_S_RUN) & bclk_en &  r_bclk;
    assign w_at_last  = (r_bidx == c_LAST);
    // A frame starts either from idle on the first enabled tick, or back to
    // back at the end of the last bit while still enabled.
    assign w_start    = ((r_state == c_S_IDLE) & bclk_en & enable)
                      | (w_fall & w_at_last & enable);
    assign w_stop     = w_fall & w_at_last & ~enable;
    assign w_adv      = w_fall & ~w_at_last;
    assign w_load     = w_start & r_full;
    assign w_bidx_nxt = r_bidx + BW'(1);
    // Word select leads each channel MSB by one bit period.
    assign w_lr_nxt   = (w_bidx_nxt >= c_LR_LO) && (w_bidx_nxt <= c_LR_HI);

    assign s_ready   = ~r_full;
    assign i2s_bclk  = r_bclk;
    assign i2s_lrclk = r_lrclk;
    assign i2s_sdata = r_sdata;
    assign busy      = r_busy;
    assign underrun  = r_underrun;

    // Holding buffer: a frame-start load empties it; a transfer fills it.
    // Both in one cycle is impossible because the load needs full=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full   <= 1'b0;
            r_hold_l <= '0;
            r_hold_r <= '0;
        end else begin
            if (w_load) begin
                r_full <= 1'b0;
            end else if (w_xfer) begin
                r_full <= 1'b1;
            end
            if (w_xfer) begin
                r_hold_l <= s_left;
                r_hold_r <= s_right;
            end
        end
    end

    // Frame state machine, bit index, shift register and line drivers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
            r_bidx  <= '0;
            r_shift <= '0;
            r_bclk  <= 1'b0;
            r_lrclk <= 1'b0;
            r_sdata <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            if (w_rise) begin
                r_bclk <= 1'b1;
            end
            if (w_fall) begin
                r_bclk <= 1'b0;
            end
            if (w_start) begin
                // Bit 0 is never in the word-select window since W >= 2.
                r_state <= c_S_RUN;
                r_busy  <= 1'b1;
                r_bidx  <= '0;
                r_lrclk <= 1'b0;
                if (r_full) begin
                    r_shift <= {r_hold_l, r_hold_r};
                    r_sdata <= r_hold_l[SAMPLE_WIDTH-1];
                end else begin
                    r_shift <= '0;
                    r_sdata <= 1'b0;
                end
            end else if (w_adv) begin
                // Shifting left keeps the current bit at the MSB position.
                r_bidx  <= w_bidx_nxt;
                r_shift <= {r_shift[FW-2:0], 1'b0};
                r_sdata <= r_shift[FW-2];
                r_lrclk <= w_lr_nxt;
            end else if (w_stop) begin
                r_state <= c_S_IDLE;
                r_busy  <= 1'b0;
                r_bidx  <= '0;
                r_lrclk <= 1'b0;
                r_sdata <= 1'b0;
            end
        end
    end

    // One-cycle underrun pulse on a frame start with an empty buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_start & ~r_full;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_tx_sequencer
//  Description : Directed self-checking bench for i2s_tx_sequencer (W=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tx_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bclk_en;
    logic        enable;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_left;
    logic [15:0] s_right;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_sdata;
    logic        busy;
    logic        underrun;

    logic [15:0] man_l;
    logic [15:0] man_r;
    logic [15:0] str_l;
    logic [15:0] str_r;
    logic        stream_on;
    int          stream_base;

    int          checks = 0;
    int          errors = 0;
    int          xfer_cnt = 0;
    int          ur_cnt = 0;
    int          ur_run = 0;
    int          ur_wide = 0;
    int          ready_hi;
    logic        prev_bclk;
    logic [31:0] cap_data;
    logic [31:0] cap_lr;
    logic [31:0] frames [8];

    assign s_left  = stream_on ? str_l : man_l;
    assign s_right = stream_on ? str_r : man_r;

    i2s_tx_sequencer #(.SAMPLE_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bclk_en   (bclk_en),
        .enable    (enable),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_left    (s_left),
        .s_right   (s_right),
        .i2s_bclk  (i2s_bclk),
        .i2s_lrclk (i2s_lrclk),
        .i2s_sdata (i2s_sdata),
        .busy      (busy),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    // bclk_en: one cycle in every four, changed on the falling clk edge.
    initial begin
        int tick_cnt;
        tick_cnt = 0;
        bclk_en  = 1'b0;
        forever begin
            @(negedge clk);
            tick_cnt++;
            bclk_en = ((tick_cnt % 4) == 0);
        end
    end

    // Streaming source: pair k is {0x1000+k, 0x2000+k} after k transfers.
    initial begin
        str_l = 16'h1000;
        str_r = 16'h2000;
        forever begin
            @(negedge clk);
            str_l = 16'h1000 + 16'(xfer_cnt - stream_base);
            str_r = 16'h2000 + 16'(xfer_cnt - stream_base);
        end
    end

    // Transfer counter.
    always @(posedge clk) begin
        if (rst_n && s_valid && s_ready) xfer_cnt <= xfer_cnt + 1;
    end

    // Underrun pulse counter and over-wide pulse detector.
    always @(negedge clk) begin
        if (underrun === 1'b1) begin
            ur_cnt <= ur_cnt + 1;
            ur_run <= ur_run + 1;
            if (ur_run == 1) ur_wide <= ur_wide + 1;
        end else begin
            ur_run <= 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick_clk(input int n);
        repeat (n) begin
            @(negedge clk);
            prev_bclk = i2s_bclk;
        end
    endtask

    task automatic capture_bits(input int n);
        for (int i = 0; i < n; i++) begin
            logic ok;
            logic cur;
            ok = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                cur = i2s_bclk;
                ok = (prev_bclk === 1'b0) && (cur === 1'b1);
                prev_bclk = cur;
                if (ok) break;
            end
            chk("bclk_rise_timeout", {63'd0, ok}, 64'd1);
            cap_data = {cap_data[30:0], i2s_sdata};
            cap_lr   = {cap_lr[30:0], i2s_lrclk};
            if (s_ready === 1'b1) ready_hi++;
        end
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        man_l   = l;
        man_r   = r;
        s_valid = 1'b1;
        tick_clk(1);
        s_valid = 1'b0;
    endtask

    task automatic idle_watch(input int n, output int bad);
        bad = 0;
        repeat (n) begin
            tick_clk(1);
            if (i2s_bclk !== 1'b0 || i2s_lrclk !== 1'b0 || i2s_sdata !== 1'b0 || busy !== 1'b0)
                bad++;
        end
    endtask

    initial begin
        int bad;
        int ur0;
        int uw0;
        rst_n       = 1'b0;
        enable      = 1'b0;
        s_valid     = 1'b0;
        man_l       = '0;
        man_r       = '0;
        stream_on   = 1'b0;
        stream_base = 0;
        prev_bclk   = 1'b0;
        cap_data    = '0;
        cap_lr      = '0;
        ready_hi    = 0;

        // Reset state and idle hold.
        tick_clk(3);
        chk("rst_outputs", {59'd0, i2s_bclk, i2s_lrclk, i2s_sdata, busy, underrun}, 64'd0);
        chk("rst_s_ready", {63'd0, s_ready}, 64'd1);
        rst_n = 1'b1;
        idle_watch(20, bad);
        chk("idle_before_enable", 64'(bad), 64'd0);

        // Single frame.
        push(16'hA5C3, 16'h0F01);
        chk("ready_low_when_full", {63'd0, s_ready}, 64'd0);
        ur0    = ur_cnt;
        enable = 1'b1;
        capture_bits(32);
        chk("frame1_data", 64'(cap_data), 64'hA5C30F01);
        chk("frame1_lrclk", 64'(cap_lr), 64'h0001FFFE);
        chk("frame1_no_underrun", 64'(ur_cnt - ur0), 64'd0);
        chk("frame1_ready_back", {63'd0, s_ready}, 64'd1);

        // Underrun frame; a pair pushed mid-frame goes out in the next frame.
        ur0 = ur_cnt;
        uw0 = ur_wide;
        capture_bits(10);
        push(16'h1234, 16'hFEDC);
        capture_bits(22);
        chk("frame2_zero", 64'(cap_data), 64'd0);
        chk("frame2_underrun_count", 64'(ur_cnt - ur0), 64'd1);
        chk("frame2_underrun_width", 64'(ur_wide - uw0), 64'd0);

        // Frame 3: drop enable at b=10 with another pair held.
        ur0 = ur_cnt;
        capture_bits(11);
        enable = 1'b0;
        push(16'h8001, 16'h7FFE);
        capture_bits(21);
        chk("frame3_data", 64'(cap_data), 64'h1234FEDC);
        chk("frame3_no_underrun", 64'(ur_cnt - ur0), 64'd0);
        tick_clk(8);
        idle_watch(40, bad);
        chk("stop_idle_quiet", 64'(bad), 64'd0);
        chk("stop_pair_held", {63'd0, s_ready}, 64'd0);

        // Restart: held pair goes first.
        ur0    = ur_cnt;
        enable = 1'b1;
        capture_bits(2);
        enable = 1'b0;
        capture_bits(30);
        chk("restart_data", 64'(cap_data), 64'h80017FFE);
        chk("restart_no_underrun", 64'(ur_cnt - ur0), 64'd0);
        tick_clk(8);
        chk("restart_stopped", {63'd0, busy}, 64'd0);

        // Streaming 8 frames.
        stream_base = xfer_cnt;
        stream_on   = 1'b1;
        tick_clk(2);
        s_valid = 1'b1;
        tick_clk(2);
        ur0      = ur_cnt;
        ready_hi = 0;
        enable   = 1'b1;
        for (int f = 0; f < 8; f++) begin
            capture_bits(32);
            frames[f] = cap_data;
        end
        enable  = 1'b0;
        s_valid = 1'b0;
        for (int f = 0; f < 8; f++) begin
            chk($sformatf("stream_frame%0d", f), 64'(frames[f]),
                {32'd0, 16'h1000 + 16'(f), 16'h2000 + 16'(f)});
        end
        chk("stream_no_underrun", 64'(ur_cnt - ur0), 64'd0);
        chk("stream_xfers", 64'(xfer_cnt - stream_base), 64'd9);
        chk("stream_ready_low", 64'(ready_hi), 64'd0);
        stream_on = 1'b0;
        tick_clk(8);

        // Asynchronous reset mid-frame at b=5 with a pair held.
        enable = 1'b1;
        capture_bits(3);
        push(16'h5555, 16'hAAAA);
        capture_bits(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", {59'd0, i2s_bclk, i2s_lrclk, i2s_sdata, busy, underrun}, 64'd0);
        chk("async_rst_s_ready", {63'd0, s_ready}, 64'd1);
        enable = 1'b0;
        tick_clk(2);
        rst_n = 1'b1;
        idle_watch(40, bad);
        chk("post_rst_idle", 64'(bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
